// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the vector multiply-accumulate sequencer.
package mac_seq_pkg;

  localparam int AW_DEF = 5;
  localparam int LW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    WRITE = 2'd3
  } mac_state_t;

endpackage

// File: rtl/mac_addr_gen.sv
// Base/length holding and wrapped rd/rs address stepping for one vector-MAC command.
module mac_addr_gen
  import mac_seq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          load,
  input  logic          start,
  input  logic          advance,
  input  logic [AW-1:0] rd_base_in,
  input  logic [AW-1:0] rs_base_in,
  input  logic [LW-1:0] len_in,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] rs_addr,
  output logic          last
);

  logic [AW-1:0] rd_base_q;
  logic [AW-1:0] rs_base_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (load) begin
      rd_base_q <= rd_base_in;
      rs_base_q <= rs_base_in;
      len_q     <= len_in;
    end
  end

  // Addresses only move when a beat is presented, so they hold outside RUN.
  // A keep command loads and starts on the same edge, hence the bypass.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_addr <= '0;
      rs_addr <= '0;
      idx_q   <= '0;
    end else if (start) begin
      rd_addr <= load ? rd_base_in : rd_base_q;
      rs_addr <= load ? rs_base_in : rs_base_q;
      idx_q   <= '0;
    end else if (advance) begin
      rd_addr <= rd_addr + AW'(1);
      rs_addr <= rs_addr + AW'(1);
      idx_q   <= idx_q + LW'(1);
    end
  end

  assign last = (idx_q == (len_q - LW'(1)));

endmodule

// File: rtl/mac_sequencer.sv
// Vector-MAC controller: sequences accumulator clear, read addresses and
// accumulate strobes for len beats, then writes back and pulses done.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_rd_base,
  input  logic [AW-1:0] cmd_rs_base,
  input  logic [LW-1:0] cmd_len,
  input  logic [AW-1:0] cmd_dest,
  input  logic          cmd_keep,
  input  logic          stall,
  input  logic          abort,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] rs_addr,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          busy,
  output logic          done,
  output logic          err
);

  mac_state_t    state;
  logic [AW-1:0] dest_q;
  logic          accept;
  logic          load;
  logic          start;
  logic          advance;
  logic          last;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_ready && cmd_valid;
  assign load      = accept && (cmd_len != '0);
  assign start     = (load && cmd_keep) || ((state == CLEAR) && !abort);
  assign advance   = (state == RUN) && !abort && !stall && !last;

  mac_addr_gen #(
    .AW(AW),
    .LW(LW)
  ) u_addr_gen (
    .clk        (clk),
    .n_reset    (n_reset),
    .load       (load),
    .start      (start),
    .advance    (advance),
    .rd_base_in (cmd_rd_base),
    .rs_base_in (cmd_rs_base),
    .len_in     (cmd_len),
    .rd_addr    (rd_addr),
    .rs_addr    (rs_addr),
    .last       (last)
  );

  always_ff @(posedge clk) begin
    if (load) dest_q <= cmd_dest;
  end

  // Strobes are one-cycle registered pulses decided on the edge that enters
  // the cycle they belong to; a stall seen in RUN suppresses the next beat.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      acc_clr <= 1'b0;
      acc_en  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      acc_clr <= 1'b0;
      acc_en  <= 1'b0;
      wr_en   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd_len == '0) begin
              err <= 1'b1;
            end else if (cmd_keep) begin
              state  <= RUN;
              acc_en <= 1'b1;
            end else begin
              state   <= CLEAR;
              acc_clr <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            state  <= RUN;
            acc_en <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (stall) begin
            state <= RUN;
          end else if (last) begin
            state   <= WRITE;
            wr_en   <= 1'b1;
            wr_addr <= dest_q;
          end else begin
            acc_en <= 1'b1;
          end
        end
        WRITE: begin
          state <= IDLE;
          done  <= !abort;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a beat-counting command model.
module tb_mac_sequencer;

  localparam int AW = 5;
  localparam int LW = 5;
  localparam int AMOD = 1 << AW;

  logic          clk;
  logic          n_reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_rd_base;
  logic [AW-1:0] cmd_rs_base;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] cmd_dest;
  logic          cmd_keep;
  logic          stall;
  logic          abort;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rs_addr;
  logic          acc_clr;
  logic          acc_en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  // Command-level model state
  bit m_busy;
  bit m_wb;
  int m_beat;
  int m_len;
  int m_rb;
  int m_sb;
  int m_dest;
  bit e_clr, e_en, e_wr, e_done, e_err;
  int e_rd, e_rs, e_wa;

  mac_sequencer #(.AW(AW), .LW(LW)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rd_base (cmd_rd_base),
    .cmd_rs_base (cmd_rs_base),
    .cmd_len     (cmd_len),
    .cmd_dest    (cmd_dest),
    .cmd_keep    (cmd_keep),
    .stall       (stall),
    .abort       (abort),
    .rd_addr     (rd_addr),
    .rs_addr     (rs_addr),
    .acc_clr     (acc_clr),
    .acc_en      (acc_en),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input int exp);
    checks++;
    if (act !== AW'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wb = 0; m_beat = 0;
    e_clr = 0; e_en = 0; e_wr = 0; e_done = 0; e_err = 0;
    e_rd = 0; e_rs = 0; e_wa = 0;
  endtask

  task automatic present(input int b);
    m_beat = b;
    e_en = 1;
    e_rd = (m_rb + b) % AMOD;
    e_rs = (m_sb + b) % AMOD;
  endtask

  // Called once per rising edge with the inputs that were held across it.
  task automatic model_step();
    e_clr = 0; e_en = 0; e_wr = 0; e_done = 0; e_err = 0;
    if (!m_busy) begin
      if (cmd_valid) begin
        if (cmd_len == 0) begin
          e_err = 1;
        end else begin
          m_busy = 1; m_wb = 0;
          m_len = int'(cmd_len);
          m_rb = int'(cmd_rd_base);
          m_sb = int'(cmd_rs_base);
          m_dest = int'(cmd_dest);
          if (cmd_keep) present(0);
          else begin
            m_beat = -1;
            e_clr = 1;
          end
        end
      end
    end else if (abort) begin
      m_busy = 0;
    end else if (m_wb) begin
      m_busy = 0;
      e_done = 1;
    end else if (m_beat < 0) begin
      present(0);
    end else if (stall) begin
      m_beat = m_beat;
    end else if (m_beat == m_len - 1) begin
      m_wb = 1;
      e_wr = 1;
      e_wa = m_dest;
    end else begin
      present(m_beat + 1);
    end
  endtask

  task automatic compare();
    chk1("m_ready", cmd_ready, !m_busy);
    chk1("m_busy", busy, m_busy);
    chk1("m_clr", acc_clr, e_clr);
    chk1("m_en", acc_en, e_en);
    chk1("m_wr", wr_en, e_wr);
    chk1("m_done", done, e_done);
    chk1("m_err", err, e_err);
    chka("m_rd", rd_addr, e_rd);
    chka("m_rs", rs_addr, e_rs);
    chka("m_wa", wr_addr, e_wa);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic send(input int rb, input int sb, input int len, input int dst, input bit keep);
    cmd_valid   = 1'b1;
    cmd_rd_base = AW'(rb);
    cmd_rs_base = AW'(sb);
    cmd_len     = LW'(len);
    cmd_dest    = AW'(dst);
    cmd_keep    = keep;
  endtask

  initial begin
    n_reset = 1'b0;
    cmd_valid = 0; cmd_rd_base = '0; cmd_rs_base = '0; cmd_len = '0;
    cmd_dest = '0; cmd_keep = 0; stall = 0; abort = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk1("rst_ready", cmd_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_strobes", acc_clr | acc_en | wr_en | done | err, 1'b0);
    chka("rst_rd", rd_addr, 0);
    chka("rst_rs", rs_addr, 0);
    chka("rst_wa", wr_addr, 0);
    n_reset = 1'b1;

    // Basic command with clear
    send(2, 23, 3, 5, 0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      cmd_valid = 0;
      chk1("basic_clr", acc_clr, c == 1);
      chk1("basic_en", acc_en, c >= 2 && c <= 4);
      if (c >= 2 && c <= 4) begin
        chka("basic_rd", rd_addr, c);
        chka("basic_rs", rs_addr, 21 + c);
      end
      chk1("basic_wr", wr_en, c == 5);
      if (c == 5) chka("basic_wa", wr_addr, 5);
      chk1("basic_done", done, c == 6);
      chk1("basic_busy", busy, c <= 5);
    end

    // Wrap with keep; a new command is offered in the done cycle
    send(30, 0, 4, 7, 1);
    for (int c = 1; c <= 7; c++) begin
      tick();
      cmd_valid = 0;
      chk1("keep_clr", acc_clr, c == 7);
      chk1("keep_en", acc_en, c >= 1 && c <= 4);
      if (c >= 1 && c <= 4) begin
        chka("keep_rd", rd_addr, (29 + c) % 32);
        chka("keep_rs", rs_addr, c - 1);
      end
      chk1("keep_wr", wr_en, c == 5);
      chk1("keep_done", done, c == 6);
      if (c == 6) send(1, 1, 2, 2, 0);
    end
    repeat (6) tick();

    // Stall on the second RUN beat for two cycles
    send(10, 20, 3, 9, 0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      cmd_valid = 0;
      stall = (c == 3 || c == 4);
      chk1("stall_en", acc_en, c == 2 || c == 3 || c == 6);
      if (c >= 2 && c <= 6)
        chka("stall_rd", rd_addr, (c == 2) ? 10 : (c == 6) ? 12 : 11);
      chk1("stall_wr", wr_en, c == 7);
      chk1("stall_done", done, c == 8);
    end
    stall = 0;

    // Zero length
    send(1, 1, 0, 3, 0);
    tick();
    cmd_valid = 0;
    chk1("zero_err", err, 1'b1);
    chk1("zero_busy", busy, 1'b0);
    chk1("zero_strobes", acc_clr | acc_en | wr_en | done, 1'b0);
    tick();
    chk1("zero_err_pulse", err, 1'b0);

    // Abort at beat 1, then back-to-back keep command
    send(0, 4, 5, 6, 0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      cmd_valid = 0;
    end
    chka("abort_rd_i1", rd_addr, 1);
    abort = 1;
    tick();
    abort = 0;
    chk1("abort_ready", cmd_ready, 1'b1);
    chk1("abort_no_wr", wr_en | done | acc_en, 1'b0);
    send(3, 3, 1, 8, 1);
    tick();
    cmd_valid = 0;
    chk1("b2b_en", acc_en, 1'b1);
    chka("b2b_rd", rd_addr, 3);
    tick();
    chk1("b2b_wr", wr_en, 1'b1);
    chka("b2b_wa", wr_addr, 8);
    tick();
    chk1("b2b_done", done, 1'b1);

    // Reset in the middle of a command
    send(5, 5, 6, 1, 0);
    tick();
    cmd_valid = 0;
    tick();
    n_reset = 1'b0;
    #1;
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_strobes", acc_clr | acc_en | wr_en | done | err, 1'b0);
    chka("mrst_rd", rd_addr, 0);
    model_reset();
    compare();
    @(negedge clk);
    n_reset = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      cmd_valid   = 1'($urandom_range(0, 1));
      cmd_rd_base = AW'($urandom_range(0, AMOD - 1));
      cmd_rs_base = AW'($urandom_range(0, AMOD - 1));
      cmd_dest    = AW'($urandom_range(0, AMOD - 1));
      cmd_keep    = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      cmd_len     = (r == 0) ? LW'(0) : (r == 9) ? LW'(31) : LW'($urandom_range(1, 6));
      stall       = ($urandom_range(0, 3) == 0);
      abort       = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
